sdhc_cmd_reg_bank: RTL and testbench
====================================

Name: sdhc_cmd_reg_bank

Overview:
Parametrised SD host register bank. It generalises the single fixed-layout command register into NUM_REGS byte-enabled registers, each with a reserved-bit mask. It adds a 4-phase write handshake, out-of-range and inhibit error reporting, and command issue on a write to the command register's high byte. It sits between the host bus adapter and the SD command engine.

Parameters:
DATA_W, 16, register width; must be a multiple of 8.
NUM_REGS, 4, number of registers.
ADDR_W, 2, address width; 2**ADDR_W >= NUM_REGS.
CMD_IDX, 3, index of the command register.
CMD_WMASK, 16'h3FFB, writable bits of the command register; 0 bits always read 0.
GEN_WMASK, 16'hFFFF, writable-bit mask for all other registers.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
wr_req  in  1  write request; held high until wr_ack
wr_addr  in  ADDR_W  target register index
wr_data  in  DATA_W  write data
wr_be  in  DATA_W/8  byte enables
wr_ack  out  1  write acknowledged; level signal, 4-phase
wr_err  out  1  valid with wr_ack; the write was rejected
rd_addr  in  ADDR_W  combinational read index
rd_data  out  DATA_W  selected register; 0 if rd_addr >= NUM_REGS
regs_flat  out  NUM_REGS*DATA_W  all registers; reg i at [i*DATA_W +: DATA_W]
busy  out  1  high in any state other than IDLE
cmd_start  out  1  one-cycle command issue pulse
cmd_inhibit  out  1  command in flight
cmd_done  in  1  command engine completion pulse

Behaviour:
- Reset values: all registers 0, FSM in IDLE, wr_ack=0, wr_err=0, cmd_start=0, cmd_inhibit=0.
- Reset asserted mid-transaction aborts the write; the register keeps its pre-write value.
- FSM states: IDLE, COMMIT, ACK.
- IDLE: on an edge with wr_req=1, capture addr, data and be, then go to COMMIT.
- COMMIT (one cycle): determine the error condition.
  - err = (addr >= NUM_REGS) or (addr == CMD_IDX and cmd_inhibit).
  - If !err, for each byte b with be[b]=1: reg[b] <= (data & mask)[b], where mask is CMD_WMASK or GEN_WMASK.
  - Bytes with be=0 are unchanged.
  - Go to ACK with wr_ack=1 and wr_err=err, both registered.
- ACK: hold wr_ack and wr_err until wr_req=0, then clear both and return to IDLE.
- Latency: wr_req sampled at edge N → register updated at edge N+1 → wr_ack high after edge N+1.
- Minimum transaction is 3 cycles.
- Command issue: a non-error COMMIT to CMD_IDX with the top byte enabled (wr_be[DATA_W/8-1]=1) does both of the following at edge N+1:
  - pulses cmd_start for exactly 1 cycle;
  - sets cmd_inhibit.
- cmd_inhibit clears on the edge after cmd_done=1.
- cmd_done while cmd_inhibit=0 is ignored.
- Simultaneous issue and cmd_done: set wins, cmd_inhibit stays 1.
- A write to CMD_IDX with wr_be top byte = 0 updates the lower bytes only and does not issue a command.
- wr_data, wr_addr and wr_be changing while in COMMIT or ACK have no effect; they were captured in IDLE.
- wr_req deasserted before wr_ack (protocol violation): the FSM still completes COMMIT, then returns to IDLE from ACK on the next edge.

Optional Feature:
SDHC_REG_PARITY_EN
- Defined:
  - Each register stores an even-parity bit, computed at COMMIT over the full masked value after merging enabled bytes.
  - Added input par_inj (1 bit): when high during COMMIT, the stored parity is inverted.
  - Added output rd_par_err (1 bit, combinational): ^{rd_data, stored_par[rd_addr]}.
  - Reset parity is 0.
- Undefined: no parity storage and no extra ports.

Decomposition:
- Package sdhc_reg_pkg:
  - state enum {IDLE, COMMIT, ACK};
  - default mask constants;
  - localparam BE_W = DATA_W/8.
- Sub-module sdhc_be_merge: combinational byte-enable/mask merge of old value, data, be and mask into the new value. It is instantiated once and reused for parity.

Test Plan:
- Reset, then write addr 0, data 16'hA5A5, be 2'b11 → wr_ack after 2 edges, wr_err=0; regs_flat[15:0]=16'hA5A5; rd_data at rd_addr=0 is 16'hA5A5.
- Partial write addr 1, data 16'h1234, be 2'b01, over 16'hFFFF → reg1=16'hFF34.
- Command write addr 3, data 16'hFFFF, be 2'b11 → reg3=16'h3FFB; cmd_start high exactly 1 cycle; cmd_inhibit=1.
- Second write to addr 3 while inhibited → wr_err=1 and reg3 unchanged. Then pulse cmd_done → cmd_inhibit=0. Rewrite with 16'h0102 → accepted.
- Write addr 3 with be 2'b01 → no cmd_start; low byte updated. Then cmd_done coincident with an issuing commit → cmd_inhibit remains 1.
- Assert rst during COMMIT of 16'h5555 to addr 2 → reg2=0, wr_ack=0, FSM in IDLE. With SDHC_REG_PARITY_EN: par_inj during a write of 16'h0001 → rd_par_err=1.

Source files
------------

// File: rtl/sdhc_reg_pkg.sv
// rtl/sdhc_reg_pkg.sv - shared types and defaults for the SD host register bank
package sdhc_reg_pkg;
  typedef enum logic [1:0] {IDLE, COMMIT, ACK} state_e;

  localparam int DEF_DATA_W = 16;
  localparam int BE_W       = DEF_DATA_W / 8;
  localparam logic [DEF_DATA_W-1:0] DEF_CMD_WMASK = 16'h3FFB;
  localparam logic [DEF_DATA_W-1:0] DEF_GEN_WMASK = 16'hFFFF;
endpackage

// File: rtl/sdhc_be_merge.sv
// rtl/sdhc_be_merge.sv - byte-enable merge of masked write data over an old register value
module sdhc_be_merge #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0]   old_i,
  input  logic [DATA_W-1:0]   data_i,
  input  logic [DATA_W-1:0]   mask_i,
  input  logic [DATA_W/8-1:0] be_i,
  output logic [DATA_W-1:0]   new_o
);
  always_comb begin
    new_o = old_i;
    for (int b = 0; b < DATA_W/8; b++) begin
      if (be_i[b]) new_o[b*8 +: 8] = data_i[b*8 +: 8] & mask_i[b*8 +: 8];
    end
  end
endmodule

// File: rtl/sdhc_cmd_reg_bank.sv
// rtl/sdhc_cmd_reg_bank.sv - SD host register bank with 4-phase writes and command issue
// Optional per-register parity storage: SDHC_REG_PARITY_EN
module sdhc_cmd_reg_bank
  import sdhc_reg_pkg::*;
#(
  parameter int                DATA_W    = 16,
  parameter int                NUM_REGS  = 4,
  parameter int                ADDR_W    = 2,
  parameter int                CMD_IDX   = 3,
  parameter logic [DATA_W-1:0] CMD_WMASK = DEF_CMD_WMASK,
  parameter logic [DATA_W-1:0] GEN_WMASK = DEF_GEN_WMASK
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_req,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [DATA_W/8-1:0]        wr_be,
  output logic                       wr_ack,
  output logic                       wr_err,
  input  logic [ADDR_W-1:0]          rd_addr,
  output logic [DATA_W-1:0]          rd_data,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic                       busy,
  output logic                       cmd_start,
  output logic                       cmd_inhibit,
  input  logic                       cmd_done
`ifdef SDHC_REG_PARITY_EN
  ,
  input  logic                       par_inj,
  output logic                       rd_par_err
`endif
);
  localparam int BW = DATA_W / 8;

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic [BW-1:0]       be_q;
  logic                ack_q, err_q, start_q, inhibit_q;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];

  logic [DATA_W-1:0]   old_val, mask_val, reg_d;
  logic                in_range, is_cmd, err_d, issue_d;

  always_comb begin
    in_range = int'(addr_q) < NUM_REGS;
    is_cmd   = int'(addr_q) == CMD_IDX;
    old_val  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(addr_q) == i) old_val = regs_q[i];
    end
    mask_val = is_cmd ? CMD_WMASK : GEN_WMASK;
    err_d    = !in_range || (is_cmd && inhibit_q);
    issue_d  = (state_q == COMMIT) && !err_d && is_cmd && be_q[BW-1];
  end

  sdhc_be_merge #(.DATA_W(DATA_W)) u_merge (
    .old_i (old_val),
    .data_i(data_q),
    .mask_i(mask_val),
    .be_i  (be_q),
    .new_o (reg_d)
  );

`ifdef SDHC_REG_PARITY_EN
  logic par_q [NUM_REGS];
  logic par_d, rd_par;
  assign par_d = (^reg_d) ^ par_inj;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      be_q      <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      start_q   <= 1'b0;
      inhibit_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
`ifdef SDHC_REG_PARITY_EN
        par_q[i]  <= 1'b0;
`endif
      end
    end else begin
      start_q <= 1'b0;
      // A new issue outranks a completion arriving on the same edge
      if (issue_d) inhibit_q <= 1'b1;
      else if (cmd_done) inhibit_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (wr_req) begin
            addr_q  <= wr_addr;
            data_q  <= wr_data;
            be_q    <= wr_be;
            state_q <= COMMIT;
          end
        end
        COMMIT: begin
          if (!err_d) begin
            for (int i = 0; i < NUM_REGS; i++) begin
              if (int'(addr_q) == i) begin
                regs_q[i] <= reg_d;
`ifdef SDHC_REG_PARITY_EN
                par_q[i]  <= par_d;
`endif
              end
            end
          end
          ack_q   <= 1'b1;
          err_q   <= err_d;
          start_q <= issue_d;
          state_q <= ACK;
        end
        ACK: begin
          if (!wr_req) begin
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
`ifdef SDHC_REG_PARITY_EN
    rd_par  = 1'b0;
`endif
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(rd_addr) == i) begin
        rd_data = regs_q[i];
`ifdef SDHC_REG_PARITY_EN
        rd_par  = par_q[i];
`endif
      end
    end
  end

`ifdef SDHC_REG_PARITY_EN
  assign rd_par_err = ^{rd_data, rd_par};
`endif

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
  end

  assign wr_ack      = ack_q;
  assign wr_err      = err_q;
  assign cmd_start   = start_q;
  assign cmd_inhibit = inhibit_q;
  assign busy        = state_q != IDLE;
endmodule

// File: tb/tb_sdhc_cmd_reg_bank.sv
// tb/tb_sdhc_cmd_reg_bank.sv - directed self-checking bench for sdhc_cmd_reg_bank
module tb_sdhc_cmd_reg_bank;
  logic        clk = 1'b0;
  logic        rst;
  logic        wr_req;
  logic [1:0]  wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  wr_be;
  logic        wr_ack, wr_err;
  logic [1:0]  rd_addr;
  logic [15:0] rd_data;
  logic [63:0] regs_flat;
  logic        busy, cmd_start, cmd_inhibit, cmd_done;
`ifdef SDHC_REG_PARITY_EN
  logic        par_inj, rd_par_err;
`endif

  int nvec = 0;
  int nerr = 0;
  int lat, st;
  logic e;

  sdhc_cmd_reg_bank dut (
    .clk        (clk),
    .rst        (rst),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_be      (wr_be),
    .wr_ack     (wr_ack),
    .wr_err     (wr_err),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .regs_flat  (regs_flat),
    .busy       (busy),
    .cmd_start  (cmd_start),
    .cmd_inhibit(cmd_inhibit),
    .cmd_done   (cmd_done)
`ifdef SDHC_REG_PARITY_EN
    ,
    .par_inj    (par_inj),
    .rd_par_err (rd_par_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full 4-phase write; lat = edges until wr_ack, st = cycles cmd_start was seen high
  task automatic wr(input logic [1:0] a, input logic [15:0] d, input logic [1:0] b,
                    output int lat_o, output int st_o, output logic err_o);
    wr_addr = a; wr_data = d; wr_be = b; wr_req = 1'b1;
    lat_o = 0; st_o = 0;
    do begin
      tick();
      lat_o++;
      if (cmd_start) st_o++;
    end while (!wr_ack && lat_o < 10);
    err_o  = wr_err;
    wr_req = 1'b0;
    tick();
    if (cmd_start) st_o++;
    tick();
    if (cmd_start) st_o++;
  endtask

  function automatic logic [15:0] rg(input logic [63:0] f, input int i);
    return f[i*16 +: 16];
  endfunction

  initial begin
    rst = 1'b1; wr_req = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
    rd_addr = '0; cmd_done = 1'b0;
`ifdef SDHC_REG_PARITY_EN
    par_inj = 1'b0;
`endif
    repeat (2) tick();
    chk("rst_ack", wr_ack, 0);
    chk("rst_err", wr_err, 0);
    chk("rst_start", cmd_start, 0);
    chk("rst_inhibit", cmd_inhibit, 0);
    chk("rst_busy", busy, 0);
    chk("rst_regs_lo", regs_flat[31:0], 0);
    chk("rst_regs_hi", regs_flat[63:32], 0);
    rst = 1'b0;
    tick();

    wr(2'd0, 16'hA5A5, 2'b11, lat, st, e);
    chk("w0_lat", lat, 2);
    chk("w0_err", e, 0);
    chk("w0_reg", rg(regs_flat, 0), 16'hA5A5);
    rd_addr = 2'd0; #1;
    chk("w0_rd", rd_data, 16'hA5A5);
    chk("w0_start", st, 0);
    chk("w0_ack_clr", wr_ack, 0);

    wr(2'd1, 16'hFFFF, 2'b11, lat, st, e);
    wr(2'd1, 16'h1234, 2'b01, lat, st, e);
    chk("w1_part", rg(regs_flat, 1), 16'hFF34);

    wr(2'd3, 16'hFFFF, 2'b11, lat, st, e);
    chk("cmd_reg", rg(regs_flat, 3), 16'h3FFB);
    chk("cmd_start1", st, 1);
    chk("cmd_inh", cmd_inhibit, 1);

    wr(2'd3, 16'h0000, 2'b11, lat, st, e);
    chk("inh_err", e, 1);
    chk("inh_reg", rg(regs_flat, 3), 16'h3FFB);
    chk("inh_start", st, 0);
    cmd_done = 1'b1; tick(); cmd_done = 1'b0;
    chk("done_clr", cmd_inhibit, 0);

    wr(2'd3, 16'h0102, 2'b11, lat, st, e);
    chk("rew_err", e, 0);
    chk("rew_reg", rg(regs_flat, 3), 16'h0102);
    chk("rew_start", st, 1);
    cmd_done = 1'b1; tick(); cmd_done = 1'b0;
    chk("rew_clr", cmd_inhibit, 0);

    wr(2'd3, 16'h00FF, 2'b01, lat, st, e);
    chk("lo_reg", rg(regs_flat, 3), 16'h01FB);
    chk("lo_start", st, 0);
    chk("lo_inh", cmd_inhibit, 0);

    // Issue and cmd_done land on the same edge
    wr_addr = 2'd3; wr_data = 16'h8000; wr_be = 2'b10; wr_req = 1'b1;
    tick();
    chk("co_busy", busy, 1);
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
    chk("co_start", cmd_start, 1);
    chk("co_inh", cmd_inhibit, 1);
    chk("co_reg", rg(regs_flat, 3), 16'h00FB);
    wr_req = 1'b0;
    tick();
    chk("co_start_pulse", cmd_start, 0);
    chk("co_inh_hold", cmd_inhibit, 1);
    tick();

    // Single-cycle wr_req plus data change after capture
    wr_addr = 2'd1; wr_data = 16'h00AA; wr_be = 2'b11; wr_req = 1'b1;
    tick();
    wr_req = 1'b0; wr_data = 16'hFFFF; wr_addr = 2'd0;
    tick();
    chk("pv_ack", wr_ack, 1);
    chk("pv_reg", rg(regs_flat, 1), 16'h00AA);
    tick();
    chk("pv_ack_clr", wr_ack, 0);
    chk("pv_idle", busy, 0);
    chk("pv_reg0", rg(regs_flat, 0), 16'hA5A5);

`ifdef SDHC_REG_PARITY_EN
    par_inj = 1'b1;
    wr(2'd0, 16'h0001, 2'b11, lat, st, e);
    par_inj = 1'b0;
    rd_addr = 2'd0; #1;
    chk("par_inj", rd_par_err, 1);
    wr(2'd0, 16'h0001, 2'b11, lat, st, e);
    #1;
    chk("par_ok", rd_par_err, 0);
`endif

    // Reset in the middle of a commit
    wr_addr = 2'd2; wr_data = 16'h5555; wr_be = 2'b11; wr_req = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    chk("mr_reg2", rg(regs_flat, 2), 16'h0000);
    chk("mr_reg3", rg(regs_flat, 3), 16'h0000);
    chk("mr_ack", wr_ack, 0);
    chk("mr_idle", busy, 0);
    chk("mr_inh", cmd_inhibit, 0);
    tick();
    wr_req = 1'b0; rst = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
